// File: rtl/param_vote_counter_if.sv
// Front-panel/readout bundle for the vote counter: async buttons and close level in, pulses and results out.
// No backpressure: buttons and close level are sampled every cycle, outputs are pulses or levels.
interface param_vote_counter_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 16
);
    localparam int WIN_W = $clog2(NUM_CAND);

    logic [NUM_CAND-1:0]       i_vote;
    logic                      i_voting_over;
    logic                      o_vote_ack;
    logic                      o_vote_reject;
    logic [NUM_CAND*CNT_W-1:0] o_tally;
    logic [WIN_W-1:0]          o_winner;
    logic                      o_tie;
    logic                      o_results_valid;
    logic [2:0]                o_state;

    modport master (
        output i_vote, i_voting_over,
        input  o_vote_ack, o_vote_reject, o_tally, o_winner, o_tie, o_results_valid, o_state
    );

    modport slave (
        input  i_vote, i_voting_over,
        output o_vote_ack, o_vote_reject, o_tally, o_winner, o_tie, o_results_valid, o_state
    );
endinterface

// File: rtl/param_vote_counter.sv
// N-candidate voting machine: debounced one-hot presses are tallied, multi-button presses rejected, results scanned on close.
// Ack 2+SETTLE_CYCLES edges after a stable press; results NUM_CAND cycles after close; no backpressure.
module param_vote_counter #(
    parameter int NUM_CAND      = 4,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    param_vote_counter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        SCAN    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CAND-1:0]  vs_meta, vs;
    logic [NUM_CAND-1:0]  hold_q, hold_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [CNT_W-1:0]     tally_q [NUM_CAND];
    logic [IDX_W-1:0]     scan_idx_q;
    logic [CNT_W-1:0]     max_q;
    logic [IDX_W-1:0]     win_q;
    logic                 tie_q;
    logic                 ack_q, ack_d;
    logic                 rej_q, rej_d;
    logic                 commit;
    logic                 vs_zero, vs_onehot, vs_multi;
    logic [NUM_CAND*CNT_W-1:0] tally_flat;

    assign vs_zero   = (vs == '0);
    assign vs_onehot = !vs_zero && ((vs & (vs - 1'b1)) == '0);
    assign vs_multi  = !vs_zero && !vs_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_meta <= '0;
            vs      <= '0;
        end else begin
            vs_meta <= bus.i_vote;
            vs      <= vs_meta;
        end
    end

    // Closing voting outranks any pending commit: an unsettled press is simply dropped.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        settle_d = settle_q;
        commit   = 1'b0;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.i_voting_over && vs_zero) state_d = ARMED;
            end
            ARMED: begin
                if (bus.i_voting_over) begin
                    state_d = SCAN;
                end else if (vs_onehot) begin
                    state_d  = HOLD;
                    hold_d   = vs;
                    settle_d = SET_W'(1);
                end else if (vs_multi) begin
                    rej_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            HOLD: begin
                if (bus.i_voting_over) begin
                    state_d = SCAN;
                end else if (vs == hold_q) begin
                    if (settle_q >= SET_W'(SETTLE_CYCLES)) begin
                        commit  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = RELEASE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end else if (vs_multi) begin
                    rej_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    state_d = ARMED;
                end
            end
            RELEASE: begin
                if (bus.i_voting_over) state_d = SCAN;
                else if (vs_zero)      state_d = ARMED;
            end
            SCAN: begin
                if (scan_idx_q == IDX_W'(NUM_CAND - 1)) state_d = DONE;
            end
            DONE: begin
                if (!bus.i_voting_over) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            settle_q <= '0;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            for (int k = 0; k < NUM_CAND; k++) tally_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            settle_q <= settle_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            if (commit) begin
                for (int k = 0; k < NUM_CAND; k++) begin
                    if (hold_q[k] && (tally_q[k] != '1)) tally_q[k] <= tally_q[k] + 1'b1;
                end
            end
        end
    end

    // Candidate 0 seeds the max; later candidates only win when strictly greater.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_q <= '0;
            max_q      <= '0;
            win_q      <= '0;
            tie_q      <= 1'b0;
        end else if (state_q == SCAN) begin
            scan_idx_q <= scan_idx_q + 1'b1;
            if (scan_idx_q == '0) begin
                max_q <= tally_q[0];
                win_q <= '0;
                tie_q <= 1'b0;
            end else if (tally_q[scan_idx_q] > max_q) begin
                max_q <= tally_q[scan_idx_q];
                win_q <= scan_idx_q;
                tie_q <= 1'b0;
            end else if (tally_q[scan_idx_q] == max_q) begin
                tie_q <= 1'b1;
            end
        end else begin
            scan_idx_q <= '0;
        end
    end

    always_comb begin
        tally_flat = '0;
        for (int k = 0; k < NUM_CAND; k++) tally_flat[k*CNT_W +: CNT_W] = tally_q[k];
    end

    assign bus.o_vote_ack      = ack_q;
    assign bus.o_vote_reject   = rej_q;
    assign bus.o_results_valid = (state_q == DONE);
    assign bus.o_tally         = (state_q == DONE) ? tally_flat : '0;
    assign bus.o_winner        = (state_q == DONE) ? win_q : '0;
    assign bus.o_tie           = (state_q == DONE) ? tie_q : 1'b0;
    assign bus.o_state         = state_q;
endmodule

// File: tb/tb_param_vote_counter.sv
module tb_param_vote_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   ack_cnt, rej_cnt, edge_cnt, first_ack, lat;

    always #5 clk = ~clk;

    param_vote_counter_if #(.NUM_CAND(4), .CNT_W(16)) b0 ();
    param_vote_counter_if #(.NUM_CAND(4), .CNT_W(2))  b1 ();

    param_vote_counter #(.NUM_CAND(4), .CNT_W(16), .SETTLE_CYCLES(4)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    param_vote_counter #(.NUM_CAND(4), .CNT_W(2), .SETTLE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    wire        ack_w    = sel ? b1.o_vote_ack      : b0.o_vote_ack;
    wire        rej_w    = sel ? b1.o_vote_reject   : b0.o_vote_reject;
    wire        valid_w  = sel ? b1.o_results_valid : b0.o_results_valid;
    wire        tie_w    = sel ? b1.o_tie           : b0.o_tie;
    wire [1:0]  win_w    = sel ? b1.o_winner        : b0.o_winner;
    wire [2:0]  state_w  = sel ? b1.o_state         : b0.o_state;
    wire [63:0] tally_w  = sel ? {14'd0, b1.o_tally[7:6], 14'd0, b1.o_tally[5:4],
                                  14'd0, b1.o_tally[3:2], 14'd0, b1.o_tally[1:0]}
                               : b0.o_tally;

    task automatic drive(input logic [3:0] v, input logic over);
        if (sel) begin
            b1.i_vote = v; b1.i_voting_over = over;
        end else begin
            b0.i_vote = v; b0.i_voting_over = over;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            edge_cnt++;
            if (ack_w) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = edge_cnt - 1;
            end
            if (rej_w) rej_cnt++;
        end
    endtask

    task automatic clear_counts;
        ack_cnt = 0; rej_cnt = 0; edge_cnt = 0; first_ack = -1;
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        drive(v, 1'b0);
        cycles(hold);
        drive(4'b0000, 1'b0);
        cycles(4);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(4'b0000, 1'b0);
        cycles(2);
        rst = 1'b0;
        cycles(3);
    endtask

    task automatic close(input logic [3:0] v, output int latency);
        latency = -1;
        drive(v, 1'b1);
        for (int i = 0; i < 20 && latency < 0; i++) begin
            cycles(1);
            if (valid_w) latency = i;
        end
    endtask

    task automatic reopen;
        drive(4'b0000, 1'b0);
        cycles(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(4'b0000, 1'b0);
        clear_counts();
        cycles(2);
        chk_cnt++; if (state_w !== 3'd0) $display("FAIL reset_state got %0d want 0", state_w); else pass_cnt++;
        chk_cnt++; if (valid_w !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_w); else pass_cnt++;
        chk_cnt++; if (tally_w !== 64'd0 || win_w !== 2'd0 || tie_w !== 1'b0)
            $display("FAIL reset_results got tally=%h win=%0d tie=%0b want 0/0/0", tally_w, win_w, tie_w);
        else pass_cnt++;
        chk_cnt++; if (ack_cnt !== 0 || rej_cnt !== 0)
            $display("FAIL reset_pulses got ack=%0d rej=%0d want 0/0", ack_cnt, rej_cnt);
        else pass_cnt++;
        rst = 1'b0;
        cycles(3);
    endtask

    task automatic test_all_zero;
        close(4'b0000, lat);
        chk_cnt++; if (lat !== 4) $display("FAIL zero_latency got %0d want 4", lat); else pass_cnt++;
        chk_cnt++; if (win_w !== 2'd0 || tie_w !== 1'b1 || tally_w !== 64'd0)
            $display("FAIL zero_result got win=%0d tie=%0b tally=%h want 0/1/0", win_w, tie_w, tally_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_single_press;
        do_reset();
        clear_counts();
        press(4'b0100, 10);
        chk_cnt++; if (ack_cnt !== 1) $display("FAIL single_ack_count got %0d want 1", ack_cnt); else pass_cnt++;
        chk_cnt++; if (first_ack !== 6) $display("FAIL single_ack_edge got %0d want 6", first_ack); else pass_cnt++;
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'h0000_0001_0000_0000 || win_w !== 2'd2 || tie_w !== 1'b0)
            $display("FAIL single_result got tally=%h win=%0d tie=%0b want tally2=1 win=2 tie=0", tally_w, win_w, tie_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_multi_reject;
        do_reset();
        clear_counts();
        press(4'b1010, 6);
        chk_cnt++; if (rej_cnt !== 1 || ack_cnt !== 0)
            $display("FAIL multi_reject got rej=%0d ack=%0d want 1/0", rej_cnt, ack_cnt);
        else pass_cnt++;
        clear_counts();
        press(4'b0010, 8);
        chk_cnt++; if (ack_cnt !== 1 || rej_cnt !== 0)
            $display("FAIL after_reject got ack=%0d rej=%0d want 1/0", ack_cnt, rej_cnt);
        else pass_cnt++;
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'h0000_0000_0001_0000 || win_w !== 2'd1 || tie_w !== 1'b0)
            $display("FAIL multi_result got tally=%h win=%0d tie=%0b want tally1=1 win=1 tie=0", tally_w, win_w, tie_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_bounce;
        do_reset();
        clear_counts();
        drive(4'b0001, 1'b0); cycles(2);
        drive(4'b0000, 1'b0); cycles(1);
        drive(4'b0001, 1'b0); cycles(6);
        drive(4'b0000, 1'b0); cycles(4);
        chk_cnt++; if (ack_cnt !== 1 || rej_cnt !== 0)
            $display("FAIL bounce_pulses got ack=%0d rej=%0d want 1/0", ack_cnt, rej_cnt);
        else pass_cnt++;
        chk_cnt++; if (first_ack !== 9) $display("FAIL bounce_ack_edge got %0d want 9", first_ack); else pass_cnt++;
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'h0000_0000_0000_0001)
            $display("FAIL bounce_tally got %h want tally0=1", tally_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_results;
        logic [3:0] seq [5];
        seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b1000};
        do_reset();
        clear_counts();
        for (int i = 0; i < 5; i++) press(seq[i], 7);
        chk_cnt++; if (ack_cnt !== 5) $display("FAIL results_acks got %0d want 5", ack_cnt); else pass_cnt++;
        close(4'b0000, lat);
        chk_cnt++; if (lat !== 4) $display("FAIL results_latency got %0d want 4", lat); else pass_cnt++;
        chk_cnt++; if (tally_w !== 64'h0003_0000_0001_0001 || win_w !== 2'd3 || tie_w !== 1'b0 || state_w !== 3'd5)
            $display("FAIL results_main got tally=%h win=%0d tie=%0b st=%0d want 0003000000010001/3/0/5",
                     tally_w, win_w, tie_w, state_w);
        else pass_cnt++;
        reopen();
        chk_cnt++; if (state_w !== 3'd1 || valid_w !== 1'b0 || tally_w !== 64'd0 || tie_w !== 1'b0)
            $display("FAIL results_secrecy got st=%0d valid=%0b tally=%h tie=%0b want 1/0/0/0",
                     state_w, valid_w, tally_w, tie_w);
        else pass_cnt++;
        press(4'b0100, 7);
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'h0003_0001_0001_0001 || win_w !== 2'd3)
            $display("FAIL results_retained got tally=%h win=%0d want 0003000100010001/3", tally_w, win_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_tie;
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0010, 4'b0100, 4'b0100};
        do_reset();
        for (int i = 0; i < 4; i++) press(seq[i], 7);
        clear_counts();
        drive(4'b0100, 1'b0);
        cycles(3);
        close(4'b0100, lat);
        chk_cnt++; if (ack_cnt !== 0) $display("FAIL tie_held_ack got %0d want 0", ack_cnt); else pass_cnt++;
        chk_cnt++; if (tally_w !== 64'h0000_0002_0002_0000 || win_w !== 2'd1 || tie_w !== 1'b1)
            $display("FAIL tie_result got tally=%h win=%0d tie=%0b want 0000000200020000/1/1", tally_w, win_w, tie_w);
        else pass_cnt++;
        drive(4'b0001, 1'b1);
        cycles(8);
        chk_cnt++; if (ack_cnt !== 0 || rej_cnt !== 0 || valid_w !== 1'b1)
            $display("FAIL done_ignores_buttons got ack=%0d rej=%0d valid=%0b want 0/0/1", ack_cnt, rej_cnt, valid_w);
        else pass_cnt++;
        reopen();
    endtask

    task automatic test_saturate_and_rst;
        sel = 1'b1;
        do_reset();
        clear_counts();
        for (int i = 0; i < 5; i++) press(4'b0001, 7);
        chk_cnt++; if (ack_cnt !== 5) $display("FAIL sat_acks got %0d want 5", ack_cnt); else pass_cnt++;
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'h0000_0000_0000_0003 || win_w !== 2'd0 || tie_w !== 1'b0)
            $display("FAIL sat_result got tally=%h win=%0d tie=%0b want tally0=3 win=0 tie=0", tally_w, win_w, tie_w);
        else pass_cnt++;
        reopen();
        press(4'b0010, 7);
        drive(4'b0000, 1'b1);
        cycles(2);
        chk_cnt++; if (state_w !== 3'd4) $display("FAIL scan_entry got st=%0d want 4", state_w); else pass_cnt++;
        rst = 1'b1;
        cycles(1);
        chk_cnt++; if (state_w !== 3'd0 || valid_w !== 1'b0 || tally_w !== 64'd0 || win_w !== 2'd0 || tie_w !== 1'b0)
            $display("FAIL rst_in_scan got st=%0d valid=%0b tally=%h win=%0d tie=%0b want all 0",
                     state_w, valid_w, tally_w, win_w, tie_w);
        else pass_cnt++;
        rst = 1'b0;
        drive(4'b0000, 1'b0);
        cycles(3);
        close(4'b0000, lat);
        chk_cnt++; if (tally_w !== 64'd0 || tie_w !== 1'b1 || lat !== 4)
            $display("FAIL rst_cleared got tally=%h tie=%0b lat=%0d want 0/1/4", tally_w, tie_w, lat);
        else pass_cnt++;
        reopen();
        sel = 1'b0;
    endtask

    initial begin
        b0.i_vote = '0; b0.i_voting_over = 1'b0;
        b1.i_vote = '0; b1.i_voting_over = 1'b0;
        @(negedge clk);
        test_reset();
        test_all_zero();
        test_single_press();
        test_multi_reject();
        test_bounce();
        test_results();
        test_tie();
        test_saturate_and_rst();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
